// File: rtl/node_integrator_pkg.sv
// node_integrator_pkg: rail/threshold constants (quoted at W=16), FSM states and a width-scaling helper.
package node_integrator_pkg;
  localparam int HI = 8192;
  localparam int LO = -8192;
  localparam int TH_HI = 2048;
  localparam int TH_LO = -2048;
  typedef enum logic [1:0] {RUN, SETTLING, SETTLED} state_t;
  function automatic int scale(input int val, input int w);
    return (w >= 16) ? (val <<< (w - 16)) : (val >>> (16 - w));
  endfunction
endpackage

// File: rtl/node_integrator_if.sv
// node_integrator_if: current inputs, hold, and the node voltage/level/settle outputs.
interface node_integrator_if #(parameter int W = 16, parameter int N = 8);
  logic [N*W-1:0] i_in;
  logic hold;
  logic signed [W-1:0] v;
  logic d;
  logic settled;
  modport master(output i_in, hold, input v, d, settled);
  modport slave(input i_in, hold, output v, d, settled);
endinterface

// File: rtl/node_integrator_current_sum.sv
// current_sum: combinational signed sum of N W-bit currents, widened so it cannot overflow.
module current_sum #(
  parameter int W = 16,
  parameter int N = 8,
  parameter int SW = W + $clog2(N)
) (
  input  logic [N*W-1:0]        i_in,
  output logic signed [SW-1:0]  o_sum
);
  always_comb begin
    o_sum = '0;
    for (int k = 0; k < N; k++) o_sum = o_sum + SW'($signed(i_in[k*W +: W]));
  end
endmodule

// File: rtl/node_integrator.sv
// node_integrator: saturating integrator of summed currents with a quiet-cycle settle detector.
// Define NODE_HYST_EN to give d threshold hysteresis instead of a plain sign decode.
module node_integrator
  import node_integrator_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 8,
  parameter int SHIFT = 2,
  parameter int INIT = 0,
  parameter int SETTLE_CYC = 8,
  parameter int EPS = 4
) (
  input logic eclk,
  input logic erst_n,
  node_integrator_if.slave bus
);
  localparam int SW = W + $clog2(N);
  localparam int AW = SW + 1;
  localparam int QW = $clog2(SETTLE_CYC + 1);
  localparam logic signed [W-1:0] V_HI = W'(scale(HI, W));
  localparam logic signed [W-1:0] V_LO = W'(scale(LO, W));
  localparam logic signed [W-1:0] T_HI = W'(scale(TH_HI, W));
  localparam logic signed [W-1:0] T_LO = W'(scale(TH_LO, W));
  localparam logic signed [W-1:0] V_INIT = (INIT != 0) ? V_HI : V_LO;
  localparam logic signed [SW-1:0] S_EPS = SW'(EPS);
  logic signed [SW-1:0] w_sum, w_delta;
  logic signed [AW-1:0] w_acc;
  logic signed [W-1:0] w_v_next;
  logic [QW-1:0] w_qinc;
  logic w_quiet, w_pinned, w_done, w_d_next;
  state_t r_state;
  logic [QW-1:0] r_qcnt;
  logic signed [W-1:0] r_v;
  logic r_d, r_settled;
  current_sum #(.W(W), .N(N), .SW(SW)) u_sum (.i_in(bus.i_in), .o_sum(w_sum));
  always_comb begin
    w_delta = w_sum >>> SHIFT;
    w_acc = AW'(r_v) + AW'(w_delta);
    w_v_next = (w_acc > AW'(V_HI)) ? V_HI : (w_acc < AW'(V_LO)) ? V_LO : W'(w_acc);
    // a node held against a rail by current pushing outward counts as quiet
    w_pinned = ((w_v_next == V_HI) && !w_sum[SW-1] && (|w_sum)) || ((w_v_next == V_LO) && w_sum[SW-1]);
    w_quiet = ((w_sum <= S_EPS) && (w_sum >= -S_EPS)) || w_pinned;
    w_qinc = r_qcnt + QW'(1);
    w_done = w_qinc >= QW'(SETTLE_CYC);
`ifdef NODE_HYST_EN
    w_d_next = (w_v_next > T_HI) ? 1'b1 : (w_v_next < T_LO) ? 1'b0 : r_d;
`else
    w_d_next = ~w_v_next[W-1];
`endif
  end
  always_ff @(posedge eclk or negedge erst_n) begin
    if (!erst_n) begin
      r_v <= V_INIT;
      r_d <= INIT[0];
      r_state <= RUN;
      r_qcnt <= '0;
      r_settled <= 1'b0;
    end else if (!bus.hold) begin
      r_v <= w_v_next;
      r_d <= w_d_next;
      if (!w_quiet) begin
        r_state <= RUN;
        r_qcnt <= '0;
        r_settled <= 1'b0;
      end else if (r_state != SETTLED) begin
        r_qcnt <= w_qinc;
        r_state <= w_done ? SETTLED : SETTLING;
        r_settled <= w_done;
      end
    end
  end
  assign bus.v = r_v;
  assign bus.d = r_d;
  assign bus.settled = r_settled;
endmodule

// File: tb/tb_node_integrator.sv
// tb_node_integrator: randomized and directed checks against a run-length integrator model.
module tb_node_integrator;
  localparam int W = 16, N = 8, SHIFT = 2, EPS = 4, SC = 8;
  logic eclk = 1'b0;
  logic erst_n;
  int n_tests = 0, n_fail = 0;
  int cur[N];
  int mv, md, mrun;
  node_integrator_if #(.W(W), .N(N)) bus();
  node_integrator #(.W(W), .N(N), .SHIFT(SHIFT), .INIT(0), .SETTLE_CYC(SC), .EPS(EPS)) dut (
    .eclk(eclk), .erst_n(erst_n), .bus(bus));
  always #5 eclk = ~eclk;

  task automatic model_reset();
    mv = -8192; md = 0; mrun = 0;
  endtask

  task automatic do_reset();
    erst_n = 1'b0;
    #2;
    erst_n = 1'b1;
    model_reset();
  endtask

  // mrun counts consecutive quiet updates; the node is settled once it reaches SC
  task automatic step(input logic h);
    int s, vn;
    logic q;
    s = 0;
    for (int k = 0; k < N; k++) begin
      bus.i_in[k*W +: W] = W'(cur[k]);
      s += cur[k];
    end
    bus.hold = h;
    @(posedge eclk);
    #1;
    if (!h) begin
      vn = mv + (s >>> SHIFT);
      vn = (vn > 8192) ? 8192 : (vn < -8192) ? -8192 : vn;
      q = (s <= EPS && s >= -EPS) || (vn == 8192 && s > 0) || (vn == -8192 && s < 0);
      mrun = q ? mrun + 1 : 0;
`ifdef NODE_HYST_EN
      md = (vn > 2048) ? 1 : (vn < -2048) ? 0 : md;
`else
      md = (vn >= 0) ? 1 : 0;
`endif
      mv = vn;
    end
  endtask

  task automatic test_reset();
    erst_n = 1'b1;
    #1 erst_n = 1'b0;
    #2;
    n_tests++;
    if (bus.v !== -16'sd8192 || bus.d !== 1'b0 || bus.settled !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: v=%0d d=%b s=%b, want v=-8192 d=0 s=0", bus.v, bus.d, bus.settled);
    end
    erst_n = 1'b1;
    model_reset();
    cur[0] = 400;
    repeat (3) step(1'b0);
    n_tests++;
    if (bus.v !== -16'sd7892) begin
      n_fail++;
      $display("FAIL reset_ramp3: v=%0d, want -7892", bus.v);
    end
    erst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.v !== -16'sd8192 || bus.d !== 1'b0 || bus.settled !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: v=%0d d=%b s=%b, want v=-8192 d=0 s=0", bus.v, bus.d, bus.settled);
    end
    erst_n = 1'b1;
    model_reset();
    cur[0] = 0;
  endtask

  task automatic test_ramp();
    do_reset();
    cur[0] = 400;
    for (int c = 1; c <= 180; c++) begin
      step(1'b0);
      n_tests++;
      if (bus.v !== W'(mv) || bus.d !== md[0] || bus.settled !== (mrun >= SC)) begin
        n_fail++;
        $display("FAIL ramp cyc %0d: v=%0d d=%b s=%b, want v=%0d d=%0d s=%0d", c, bus.v, bus.d, bus.settled, mv, md, mrun >= SC);
      end
      if (c == 1) begin
        n_tests++;
        if (bus.v !== -16'sd8092) begin
          n_fail++;
          $display("FAIL ramp_first: v=%0d, want -8092", bus.v);
        end
      end
    end
    n_tests++;
    if (bus.v !== 16'sd8192 || bus.settled !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_clamp: v=%0d s=%b, want v=8192 s=1", bus.v, bus.settled);
    end
    cur[0] = 0;
  endtask

  task automatic test_hysteresis();
    do_reset();
    cur[0] = 400;
    repeat (112) step(1'b0);
    n_tests++;
    if (bus.v !== 16'sd3008 || bus.d !== 1'b1) begin
      n_fail++;
      $display("FAIL hyst_top: v=%0d d=%b, want v=3008 d=1", bus.v, bus.d);
    end
    cur[0] = -400;
    for (int j = 1; j <= 51; j++) begin
      step(1'b0);
      n_tests++;
      if (bus.v !== W'(mv) || bus.d !== md[0]) begin
        n_fail++;
        $display("FAIL hyst_down cyc %0d: v=%0d d=%b, want v=%0d d=%0d", j, bus.v, bus.d, mv, md);
      end
      if (j == 31) begin
        n_tests++;
`ifdef NODE_HYST_EN
        if (bus.v !== -16'sd92 || bus.d !== 1'b1) begin
          n_fail++;
          $display("FAIL hyst_below0: v=%0d d=%b, want v=-92 d=1", bus.v, bus.d);
        end
`else
        if (bus.v !== -16'sd92 || bus.d !== 1'b0) begin
          n_fail++;
          $display("FAIL hyst_below0: v=%0d d=%b, want v=-92 d=0", bus.v, bus.d);
        end
`endif
      end
    end
    n_tests++;
    if (bus.v !== -16'sd2092 || bus.d !== 1'b0) begin
      n_fail++;
      $display("FAIL hyst_bottom: v=%0d d=%b, want v=-2092 d=0", bus.v, bus.d);
    end
    cur[0] = 0;
  endtask

  task automatic test_settle();
    int pulse[3] = '{0, 5, 4};
    int start[3] = '{0, 5, 0};
    for (int p = 0; p < 3; p++) begin
      do_reset();
      for (int c = 1; c <= 16; c++) begin
        cur[0] = (c == 5) ? pulse[p] : 0;
        step(1'b0);
        n_tests++;
        if (bus.settled !== (c >= start[p] + SC) || bus.v !== W'(mv)) begin
          n_fail++;
          $display("FAIL settle p=%0d cyc %0d: s=%b v=%0d, want s=%0d v=%0d", pulse[p], c, bus.settled, bus.v, c >= start[p] + SC, mv);
        end
      end
    end
    cur[0] = 0;
  endtask

  task automatic test_hold_reset();
    do_reset();
    repeat (4) step(1'b0);
    cur[0] = 400;
    repeat (3) step(1'b1);
    n_tests++;
    if (bus.v !== -16'sd8192 || bus.settled !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_freeze: v=%0d s=%b, want v=-8192 s=0", bus.v, bus.settled);
    end
    cur[0] = 0;
    for (int c = 1; c <= 4; c++) begin
      step(1'b0);
      n_tests++;
      if (bus.settled !== (c == 4)) begin
        n_fail++;
        $display("FAIL hold_resume cyc %0d: s=%b, want %0d", c, bus.settled, c == 4);
      end
    end
    do_reset();
    repeat (5) step(1'b0);
    erst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.settled !== 1'b0 || bus.v !== -16'sd8192) begin
      n_fail++;
      $display("FAIL reset_mid_settle: s=%b v=%0d, want s=0 v=-8192", bus.settled, bus.v);
    end
    erst_n = 1'b1;
    model_reset();
    for (int c = 1; c <= SC; c++) begin
      step(1'b0);
      n_tests++;
      if (bus.settled !== (c == SC)) begin
        n_fail++;
        $display("FAIL restart_settle cyc %0d: s=%b, want %0d", c, bus.settled, c == SC);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic h;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = int'($urandom_range(9));
      for (int k = 0; k < N; k++)
        cur[k] = (r < 3) ? ((k < 2) ? int'($urandom_range(6)) - 3 : 0) :
                 (r == 3) ? int'($signed(16'($urandom))) : int'($urandom_range(1600)) - 800;
      h = ($urandom_range(9) == 0);
      step(h);
      n_tests++;
      if (bus.v !== W'(mv) || bus.d !== md[0] || bus.settled !== (mrun >= SC)) begin
        n_fail++;
        $display("FAIL random cyc %0d: v=%0d d=%b s=%b, want v=%0d d=%0d s=%0d", c, bus.v, bus.d, bus.settled, mv, md, mrun >= SC);
      end
    end
    foreach (cur[k]) cur[k] = 0;
  endtask

  initial begin
    erst_n = 1'b1;
    bus.hold = 1'b0;
    bus.i_in = '0;
    foreach (cur[k]) cur[k] = 0;
    model_reset();
    test_reset();
    test_ramp();
    test_hysteresis();
    test_settle();
    test_hold_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/node_integrator.md
NODE_INTEGRATOR -- requirements
Module: node_integrator

Interface
- REQ-001 The block SHALL have parameter W, default 16, giving the signed voltage and current width.
- REQ-002 The block SHALL have parameter N, default 8, giving the number of current inputs.
- REQ-003 The block SHALL have parameter SHIFT, default 2, giving the integration gain as an arithmetic right shift of the summed current.
- REQ-004 The block SHALL have parameter INIT, default 0, selecting the reset voltage: 0 gives LO, 1 gives HI.
- REQ-005 The block SHALL have parameter SETTLE_CYC, default 8, giving the number of consecutive quiet cycles needed to declare the node settled.
- REQ-006 The block SHALL have parameter EPS, default 4, giving the quiet threshold on |sum|.
- REQ-007 eclk  input  1  clock; all state updates on the rising edge.
- REQ-008 erst_n  input  1  reset; asynchronous, active-low.
- REQ-009 i_in  input  N*W  signed currents, slice k = i_in[k*W +: W].
- REQ-010 hold  input  1  freezes v and the settle state while high.
- REQ-011 v  output  W  signed node voltage, registered.
- REQ-012 d  output  1  digital level of the node, registered.
- REQ-013 settled  output  1  high while the FSM is in SETTLED.

Function
- REQ-014 Each cycle the block SHALL form sum as the signed sum of all N inputs, at width W+$clog2(N) with no overflow.
- REQ-015 If hold=0, the block SHALL set v_next = sat(v + (sum >>> SHIFT)), clamped to [LO, HI].
- REQ-016 The latency from i_in to v SHALL be 1 cycle.
- REQ-017 A quiet cycle SHALL be defined as |sum| <= EPS; the boundary value EPS counts as quiet.
- REQ-018 The FSM SHALL have states RUN, SETTLING and SETTLED, with a quiet counter qcnt of width $clog2(SETTLE_CYC+1).
- REQ-019 RUN SHALL go to SETTLING on a quiet cycle with qcnt=1; a non-quiet cycle SHALL hold RUN with qcnt=0.
- REQ-020 SETTLING SHALL increment qcnt on each quiet cycle and go to SETTLED when qcnt reaches SETTLE_CYC.
- REQ-021 SETTLING SHALL return to RUN with qcnt=0 on any non-quiet cycle.
- REQ-022 SETTLED SHALL go to RUN with qcnt=0 on any non-quiet cycle; settled SHALL fall in that same registered update.
- REQ-023 While hold=1, v, d, the FSM state and qcnt SHALL be unchanged.
- REQ-024 When the result saturates and the incoming current pushes further into the rail, the block SHALL treat the cycle as quiet (rail-pinned node settles).
- REQ-025 d SHALL be computed from v_next, so d is aligned with v.

Reset
- REQ-026 While erst_n=0, the block SHALL set v to LO if INIT=0 and to HI if INIT=1.
- REQ-027 While erst_n=0, the block SHALL set d to INIT, the state to RUN, qcnt to 0 and settled to 0.
- REQ-028 Reset asserted mid-settle SHALL discard all progress; release SHALL restart from RUN.

Configuration
- REQ-029 With NODE_HYST_EN defined, d SHALL set when v_next > TH_HI, clear when v_next < TH_LO, and otherwise hold.
- REQ-030 Without NODE_HYST_EN, d SHALL be the pure sign decode ~v_next[W-1], with no thresholds.

Structure
- REQ-031 The shared package SHALL hold HI (+8192 at W=16), LO (-8192), TH_HI (+2048), TH_LO (-2048) and the FSM state enum.
- REQ-032 The block SHALL use one sub-module, current_sum, a combinational signed adder over the N inputs, instantiated once.

Verification (W=16, N=8, SHIFT=2, EPS=4, SETTLE_CYC=8, INIT=0)
- REQ-033 Reset: erst_n=0 -> v=-8192, d=0, settled=0 immediately, with no clock edge.
- REQ-034 Ramp: one input at +400, others 0 -> v rises by 100 per cycle and clamps at +8192; d rises when v first exceeds +2048 (hysteresis build).
- REQ-035 Settle: all inputs 0 -> settled=1 after exactly 8 cycles; a single input of +5 on cycle 5 resets the count and settled=1 comes 8 cycles later; an input of +4 does not reset the count.
- REQ-036 Hysteresis: drive v from +3000 down to 0 -> d stays 1; continue to -2100 -> d=0 (NODE_HYST_EN); without the macro, d=0 as soon as v<0.
- REQ-037 Hold and reset: hold=1 with +400 input -> v unchanged; erst_n pulsed low while SETTLING -> state RUN and settled=0.
